write_port_buffer: RTL
======================

# write_port_buffer

Per-port ingress packet buffer that sits directly upstream of the write arbiter core; one instance per input port. It stores incoming packet words in a data FIFO plus a descriptor FIFO and presents `ready` and a head-of-line `priority` to the arbiter. When granted through `next_data`, it streams the head packet one word per cycle and flags the last word with `eop`. It also drops packets that overflow the buffer.

## Interface
- `DATA_WIDTH`, 32, packet word width
- `DEPTH`, 64, data FIFO depth in words; power of 2; also the maximum packet length
- `PKT_DEPTH`, 8, descriptor FIFO depth in packets; power of 2
- `priority_width`, 3, priority field width
- `clk  in  1  clock`; all logic on the rising edge
- `rst  in  1  asynchronous, active-low reset (asserted when 0)`
- `wr_vld  in  1  input word valid`
- `wr_sop  in  1  first word of a packet; qualified by wr_vld`
- `wr_eop  in  1  last word of a packet; qualified by wr_vld`
- `wr_data  in  DATA_WIDTH  input word`
- `wr_priority  in  priority_width  packet priority; sampled only on the sop word`
- `wr_full  out  1  no free data word; registered`
- `ready  out  1  at least one complete packet stored`
- `priority  out  priority_width  priority of the head packet; 0 when empty`
- `next_data  in  1  level grant from the arbiter`
- `rd_vld  out  1  rd_data valid`
- `rd_data  out  DATA_WIDTH  output word`
- `eop  out  1  rd_data is the last word of the packet`
- `drop_cnt  out  8  dropped-packet count; saturates at 255`

## Operation
- Reset values: all outputs 0, both FIFOs empty, write FSM in IDLE, read FSM in ARMED.
- Write FSM has three states: IDLE, PKT, DROP.
  - IDLE:
    - `wr_vld & wr_sop`: write the word, latch priority, set length=1, go to PKT. If the word also has `wr_eop`, commit immediately.
    - `wr_vld` without sop: ignore the word.
  - PKT:
    - Each `wr_vld` word is written and length is incremented.
    - On `wr_eop`: commit. Push the {length, priority} descriptor, set the committed pointer to the write pointer, go to IDLE.
  - Start of a packet is dropped (IDLE sop word → DROP) if the descriptor FIFO is full at sop, or `wr_full` is high at sop.
  - Overflow (PKT → DROP): `wr_vld` while `wr_full`, or length would exceed `DEPTH`.
  - sop while in PKT: abort the current packet by rewinding the write pointer to the committed pointer, then treat the word as a new sop.
  - DROP: rewind the write pointer to the committed pointer and ignore words. `wr_eop` goes to IDLE; `wr_sop` starts a new packet with the IDLE rules.
  - Every dropped or aborted packet increments `drop_cnt` once.
- `wr_full` = (write pointer − read pointer) == `DEPTH`. Uncommitted words count as occupied.
- Read FSM has three states: ARMED, XFER, WAIT_LOW.
  - ARMED: when `next_data` is high and `ready` is high, load length from the head descriptor and go to XFER.
  - XFER: each cycle with `next_data` high, output one word and decrement the remaining count. With `next_data` low, stall: `rd_vld` is 0 and position is held.
  - On the last word: `eop`=1, pop the descriptor, go to WAIT_LOW.
  - WAIT_LOW: ignore `next_data` until it is sampled 0, then return to ARMED. This absorbs the arbiter's registered grant-drop latency so a following packet is never streamed under the old grant.
- `ready` = descriptor count != 0. It stays high during a transfer if further packets are queued.
- `priority` follows the head descriptor and updates the cycle after a pop.
- Simultaneous push and pop: descriptor count is unchanged and `ready` holds.

## Timing
- Write: the eop word accepted at edge N → `ready` and `priority` valid after edge N+1.
- Read: `next_data` sampled high at edge M in ARMED → first word (`rd_vld`=1) valid after edge M+1. After that, one word per cycle while `next_data` is high.
- `eop` is coincident with the last `rd_vld` cycle.
- Minimum gap between packets on the read side: 2 cycles (WAIT_LOW plus re-arm).
- Data FIFO words are freed as they are read; `wr_full` can deassert the cycle after a read.
- Reset mid-transfer or mid-write: immediately empties both FIFOs and forces all outputs to 0. No partial packet survives reset.

## Test plan
- Write a 4-word packet with priority 5 → `ready`=1 and `priority`=5 one cycle after the eop word. Hold `next_data` high → words 0..3 on 4 consecutive cycles, `eop` on word 3, then `ready`=0.
- Queue two packets (3 words at priority 2, 2 words at priority 6). Keep `next_data` high through the first eop → the second packet does not start until `next_data` has been low for ≥1 cycle; `priority` becomes 6 after the first pop.
- Toggle `next_data` low for 2 cycles mid-packet → `rd_vld`=0 during the stall, no word lost or duplicated, order preserved.
- With `DEPTH`=64, write a 70-word packet → dropped, `drop_cnt`=1, `ready` stays 0. A following 2-word packet is accepted and reads back intact.
- Fill `PKT_DEPTH`=8 descriptors, then send a 9th packet → `drop_cnt` increments and the first 8 packets read back intact.
- Assert `rst`=0 mid-transfer → all outputs 0 immediately (asynchronous). After release, a new 1-word packet reads back with `eop`=1 on its single word.

Source files
------------

// File: rtl/write_port_buffer.sv
// write_port_buffer: per-port ingress packet buffer feeding the write arbiter.
// In: clk, rst (async, low), wr_vld/sop/eop/data/priority, next_data (grant).
// Out: wr_full, ready, prio (head-of-line priority), rd_vld/rd_data/eop,
//      drop_cnt (saturating count of dropped or aborted packets).
module write_port_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 64,
  parameter int PKT_DEPTH      = 8,
  parameter int priority_width = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_vld,
  input  logic                      wr_sop,
  input  logic                      wr_eop,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [priority_width-1:0] wr_priority,
  output logic                      wr_full,
  output logic                      ready,
  output logic [priority_width-1:0] prio,
  input  logic                      next_data,
  output logic                      rd_vld,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      eop,
  output logic [7:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PKT_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW:0]   DEPTH_P  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);
  localparam logic [PW:0]   PKT_FULL = (PW+1)'(PKT_DEPTH);
  localparam logic [PW-1:0] DP_ONE   = PW'(1);
  localparam logic [PW:0]   DC_ONE   = (PW+1)'(1);

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_ARMED, R_XFER, R_WAIT_LOW} rstate_t;

  wstate_t ws, ws_n;
  rstate_t rs, rs_n;

  logic [DATA_WIDTH-1:0]     mem   [DEPTH];
  logic [LW-1:0]             d_len [PKT_DEPTH];
  logic [priority_width-1:0] d_pri [PKT_DEPTH];

  logic [AW:0]               wr_ptr, cmt_ptr, rd_ptr;
  logic [AW:0]               wp_n, cp_n, rp_n;
  logic [AW-1:0]             wa;
  logic [LW-1:0]             len, len_n, rem, rem_n;
  logic [priority_width-1:0] cur_pri, pri_n;
  logic [PW-1:0]             dw_ptr, dr_ptr;
  logic [PW:0]               d_cnt;
  logic                      we, push, pop, sop_ok;
  logic                      rd_adv, vld_n, eop_n;
  logic [1:0]                drops;
  logic [8:0]                dsum;

  // Write side. A sop always restarts from the committed pointer, which
  // both aborts an open packet and leaves DROP rewound.
  always_comb begin
    ws_n   = ws;
    wp_n   = wr_ptr;
    cp_n   = cmt_ptr;
    wa     = wr_ptr[AW-1:0];
    len_n  = len;
    pri_n  = cur_pri;
    we     = 1'b0;
    push   = 1'b0;
    drops  = 2'd0;
    sop_ok = (d_cnt != PKT_FULL) &&
             ((cmt_ptr - rd_ptr) != DEPTH_P);
    if (wr_vld && wr_sop) begin
      if (ws == W_PKT) drops = 2'd1;
      wa   = cmt_ptr[AW-1:0];
      wp_n = cmt_ptr;
      if (sop_ok) begin
        we    = 1'b1;
        wp_n  = cmt_ptr + PTR_ONE;
        len_n = LEN_ONE;
        pri_n = wr_priority;
        if (wr_eop) begin
          push = 1'b1;
          cp_n = wp_n;
          ws_n = W_IDLE;
        end else begin
          ws_n = W_PKT;
        end
      end else begin
        drops = drops + 2'd1;
        ws_n  = wr_eop ? W_IDLE : W_DROP;
      end
    end else if (wr_vld) begin
      unique case (ws)
        W_PKT: begin
          if (wr_full || len == DEPTH_P) begin
            drops = 2'd1;
            wp_n  = cmt_ptr;
            ws_n  = wr_eop ? W_IDLE : W_DROP;
          end else begin
            we    = 1'b1;
            wp_n  = wr_ptr + PTR_ONE;
            len_n = len + LEN_ONE;
            if (wr_eop) begin
              push = 1'b1;
              cp_n = wp_n;
              ws_n = W_IDLE;
            end
          end
        end
        W_DROP: if (wr_eop) ws_n = W_IDLE;
        default: ;
      endcase
    end
  end

  // Read side. WAIT_LOW holds off re-arming until the grant is seen low.
  always_comb begin
    rs_n   = rs;
    rem_n  = rem;
    rd_adv = 1'b0;
    vld_n  = 1'b0;
    eop_n  = 1'b0;
    pop    = 1'b0;
    unique case (rs)
      R_ARMED: begin
        if (next_data && ready) begin
          rem_n = d_len[dr_ptr];
          rs_n  = R_XFER;
        end
      end
      R_XFER: begin
        if (next_data) begin
          rd_adv = 1'b1;
          vld_n  = 1'b1;
          rem_n  = rem - LEN_ONE;
          if (rem == LEN_ONE) begin
            eop_n = 1'b1;
            pop   = 1'b1;
            rs_n  = R_WAIT_LOW;
          end
        end
      end
      R_WAIT_LOW: if (!next_data) rs_n = R_ARMED;
      default: rs_n = R_ARMED;
    endcase
  end

  assign rp_n = rd_adv ? rd_ptr + PTR_ONE : rd_ptr;
  assign dsum = {1'b0, drop_cnt} + {7'd0, drops};

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wr_data;
    if (push) begin
      d_len[dw_ptr] <= len_n;
      d_pri[dw_ptr] <= pri_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws       <= W_IDLE;
      rs       <= R_ARMED;
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      len      <= '0;
      rem      <= '0;
      cur_pri  <= '0;
      dw_ptr   <= '0;
      dr_ptr   <= '0;
      d_cnt    <= '0;
      wr_full  <= 1'b0;
      ready    <= 1'b0;
      prio     <= '0;
      rd_vld   <= 1'b0;
      rd_data  <= '0;
      eop      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ws      <= ws_n;
      rs      <= rs_n;
      wr_ptr  <= wp_n;
      cmt_ptr <= cp_n;
      rd_ptr  <= rp_n;
      len     <= len_n;
      rem     <= rem_n;
      cur_pri <= pri_n;
      wr_full <= (wp_n - rp_n) == DEPTH_P;
      rd_vld  <= vld_n;
      eop     <= eop_n;
      if (rd_adv) rd_data <= mem[rd_ptr[AW-1:0]];
      if (push) dw_ptr <= dw_ptr + DP_ONE;
      if (pop) dr_ptr <= dr_ptr + DP_ONE;
      unique case ({push, pop})
        2'b10:   d_cnt <= d_cnt + DC_ONE;
        2'b01:   d_cnt <= d_cnt - DC_ONE;
        default: ;
      endcase
      // Head status is registered from the descriptor state.
      ready    <= d_cnt != '0;
      prio     <= (d_cnt != '0) ? d_pri[dr_ptr] : '0;
      drop_cnt <= dsum[8] ? 8'hFF : dsum[7:0];
    end
  end

endmodule
